// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage.
// master drives the word address, slave returns combinational read data.
interface if_stage_if #(
  parameter int AW = 10
);
  logic [AW-1:0] im_addr;
  logic [31:0]   im_rdata;

  modport master (
    output im_addr,
    input  im_rdata
  );

  modport slave (
    input  im_addr,
    output im_rdata
  );
endinterface

// File: rtl/if_stage.sv
// P5 MIPS instruction-fetch stage: PC, delayed-branch NPC select,
// instruction-memory addressing and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_true,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] rs_val,
  if_stage_if.master  im,
  output logic [31:0] if_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        align_err,
  output logic [31:0] fetch_cnt
);

  localparam int AW = $clog2(IM_DEPTH);
  localparam logic [32:0] IM_BYTES = 33'(IM_DEPTH) * 33'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } if_id_t;

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] off;
  logic [31:0] pc4;
  logic [31:0] id_pc4;
  logic [31:0] boff;
  logic [31:0] fword;
  logic        in_range;
  logic        mis_jr;
  if_id_t      ifid;

  assign off      = pc - IM_BASE;
  assign in_range = (pc >= IM_BASE) && ({1'b0, off} < IM_BYTES);
  assign im.im_addr = off[AW+1:2];
  assign fword    = in_range ? im.im_rdata : 32'h0;

  assign pc4    = pc + 32'd4;
  assign id_pc4 = ifid.pc + 32'd4;
  assign boff   = {{14{id_imm16[15]}}, id_imm16, 2'b00};
  assign mis_jr = (npc_sel == 2'b11) && (rs_val[1:0] != 2'b00);

  // Branch/jump targets come from the ID instruction; IF holds its delay slot.
  always_comb begin
    npc = pc4;
    unique case (npc_sel)
      2'b00: npc = pc4;
      2'b01: npc = br_true ? id_pc4 + boff : pc4;
      2'b10: npc = {id_pc4[31:28], id_index26, 2'b00};
      2'b11: npc = {rs_val[31:2], 2'b00};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= PC_RESET;
      ifid      <= '0;
      align_err <= 1'b0;
      fetch_cnt <= 32'h0;
    end else if (!stall) begin
      pc         <= npc;
      ifid.instr <= fword;
      ifid.pc    <= pc;
      ifid.pc8   <= pc + 32'd8;
      ifid.valid <= 1'b1;
      if (in_range) fetch_cnt <= fetch_cnt + 32'd1;
      if (mis_jr)   align_err <= 1'b1;
    end
  end

  assign if_pc    = pc;
  assign id_instr = ifid.instr;
  assign id_pc    = ifid.pc;
  assign id_pc8   = ifid.pc8;
  assign id_valid = ifid.valid;

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage against a
// cycle-level architectural model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_true;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [31:0] rs_val;
  logic [31:0] if_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic        align_err;
  logic [31:0] fetch_cnt;

  logic [31:0] mem [0:DEPTH-1];

  if_stage_if #(.AW(10)) imb ();

  assign imb.im_rdata = mem[imb.im_addr];

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .br_true    (br_true),
    .id_imm16   (id_imm16),
    .id_index26 (id_index26),
    .rs_val     (rs_val),
    .im         (imb.master),
    .if_pc      (if_pc),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc8     (id_pc8),
    .id_valid   (id_valid),
    .align_err  (align_err),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_instr, m_idpc, m_idpc8, m_cnt;
  bit          m_valid, m_err, m_known;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit inr(input logic [31:0] a);
    longint d;
    d = longint'(a) - longint'(BASE);
    return (d >= 0) && (d < 4 * DEPTH);
  endfunction

  task automatic cyc(input bit rst, input bit stl, input logic [1:0] sel,
                     input bit bt, input logic [15:0] imm,
                     input logic [25:0] idx, input logic [31:0] rs);
    logic [31:0] n, sx, link;
    reset = rst; stall = stl; npc_sel = sel; br_true = bt;
    id_imm16 = imm; id_index26 = idx; rs_val = rs;
    #1;
    if (m_known) begin
      chk("im_addr", 32'(imb.im_addr), ((m_pc - BASE) / 4) % DEPTH);
    end
    sx = {{16{imm[15]}}, imm};
    link = m_idpc + 4;
    case (sel)
      2'd0: n = m_pc + 4;
      2'd1: n = bt ? link + sx * 4 : m_pc + 4;
      2'd2: n = (link / 32'h1000_0000) * 32'h1000_0000 + 32'(idx) * 4;
      default: n = rs - (rs % 4);
    endcase
    if (!rst) begin
      m_pc = BASE; m_instr = 0; m_idpc = 0; m_idpc8 = 0;
      m_valid = 0; m_err = 0; m_cnt = 0; m_known = 1;
    end else if (!stl) begin
      if (sel == 2'd3 && rs % 4 != 0) m_err = 1;
      m_instr = inr(m_pc) ? mem[(m_pc - BASE) / 4] : 32'h0;
      m_idpc  = m_pc;
      m_idpc8 = m_pc + 8;
      m_valid = 1;
      if (inr(m_pc)) m_cnt = m_cnt + 1;
      m_pc = n;
    end
    @(posedge clk);
    #1;
    chk("if_pc", if_pc, m_pc);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc", id_pc, m_idpc);
    chk("id_pc8", id_pc8, m_idpc8);
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("align_err", 32'(align_err), 32'(m_err));
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic rst_c();
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic seq_c();
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  initial begin
    logic [1:0]  s;
    logic [31:0] r;
    m_known = 0;
    reset = 1; stall = 0; npc_sel = 0; br_true = 0;
    id_imm16 = 0; id_index26 = 0; rs_val = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h3c01_1234;
    mem[1] = 32'h3421_0001;
    mem[2] = 32'h0000_0000;

    rst_c();
    chk("rst_pc", if_pc, 32'h3000);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    seq_c();
    chk("f0_instr", id_instr, 32'h3c01_1234);
    chk("f0_pc8", id_pc8, 32'h3008);
    seq_c();
    chk("f1_instr", id_instr, 32'h3421_0001);
    chk("f1_pc", id_pc, 32'h3004);
    seq_c();
    chk("f2_instr", id_instr, 32'h0);
    chk("f2_pc", id_pc, 32'h3008);
    chk("f2_cnt", fetch_cnt, 32'd3);

    rst_c(); seq_c(); seq_c();
    cyc(1'b1, 1'b0, 2'd1, 1'b1, 16'hfffe, 26'h0, 32'h0);
    chk("bt_pc", if_pc, 32'h3000);
    chk("bt_slot", id_pc, 32'h3008);
    rst_c(); seq_c(); seq_c();
    cyc(1'b1, 1'b0, 2'd1, 1'b0, 16'hfffe, 26'h0, 32'h0);
    chk("bnt_pc", if_pc, 32'h300c);

    rst_c();
    for (int i = 0; i < 5; i++) seq_c();
    chk("j_idpc", id_pc, 32'h3010);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000c10, 32'h0);
    chk("j_pc", if_pc, 32'h3040);
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3022);
    chk("jr_pc", if_pc, 32'h3020);
    chk("jr_err", 32'(align_err), 32'h1);
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3000);
    chk("jr_err_hold", 32'(align_err), 32'h1);

    rst_c(); seq_c(); seq_c();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 2'd1, 1'b1, 16'hfffe, 26'h0, 32'h0);
      chk("stl_pc", if_pc, 32'h3008);
      chk("stl_idpc", id_pc, 32'h3004);
      chk("stl_cnt", fetch_cnt, 32'd2);
    end
    cyc(1'b1, 1'b0, 2'd1, 1'b1, 16'hfffe, 26'h0, 32'h0);
    chk("stl_redir", if_pc, 32'h3000);

    rst_c(); seq_c();
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h2ffc);
    chk("oor_pc", if_pc, 32'h2ffc);
    seq_c();
    chk("oor_instr", id_instr, 32'h0);
    chk("oor_cnt", fetch_cnt, 32'd2);
    cyc(1'b0, 1'b1, 2'd1, 1'b1, 16'h0010, 26'h0, 32'h0);
    chk("rstall_pc", if_pc, 32'h3000);
    chk("rstall_valid", 32'(id_valid), 32'h0);

    for (int i = 0; i < 400; i++) begin
      s = 2'($urandom_range(0, 3));
      r = BASE - 32'd64 + 32'($urandom_range(0, 4 * DEPTH + 128));
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0), s,
          1'($urandom), 16'($signed($urandom_range(0, 80)) - 40),
          26'(32'h0c00 + $urandom_range(0, DEPTH + 20)), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the P5 five-stage MIPS pipeline: the producer of the instruction words the ID-stage control decoder consumes.
- Holds the PC and computes the next PC from the decoder's NPC select plus branch outcome, using delayed-branch semantics (one delay slot).
- Drives the instruction-memory address, and loads the IF/ID pipeline register with instruction, PC and PC+8 (link value).

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset
IM_BASE, 32'h0000_3000, byte address of instruction word 0
IM_DEPTH, 1024, instruction memory depth in words (power of two)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge)
stall  input  1  hazard-unit stall; freezes PC and IF/ID
npc_sel  input  2  from ID decoder: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr
br_true  input  1  ID comparator result for the branch in ID
id_imm16  input  16  imm field of the ID instruction
id_index26  input  26  instr_index field of the ID instruction
rs_val  input  32  forwarded GPR[rs] in ID (jr/jalr target)
im_addr  output  clog2(IM_DEPTH)  word index into instruction memory
im_rdata  input  32  combinational instruction-memory read data
if_pc  output  32  current PC
id_instr  output  32  IF/ID instruction
id_pc  output  32  IF/ID PC
id_pc8  output  32  IF/ID PC+8, jal/jalr/bgezal link value
id_valid  output  1  IF/ID holds a fetched (non-reset) instruction
align_err  output  1  sticky: misaligned jr/jalr target seen
fetch_cnt  output  32  count of valid instructions loaded into IF/ID

Behaviour:
- Reset (reset==0 at edge, overrides stall):
  - PC=PC_RESET.
  - id_instr=0 (nop), id_pc=0, id_pc8=0.
  - id_valid=0, align_err=0, fetch_cnt=0.
- Memory addressing:
  - im_addr=(PC-IM_BASE)[clog2(IM_DEPTH)+1:2], combinational from PC.
  - in_range = (PC >= IM_BASE) && (PC-IM_BASE < 4*IM_DEPTH).
  - Fetched word = in_range ? im_rdata : 32'h0.
- NPC is combinational; branch targets are relative to the ID instruction, so the instruction in IF is the delay slot.
  - 00: PC+4.
  - 01: br_true ? id_pc+4+(sext(id_imm16)<<2) : PC+4.
  - 10: {id_pc4[31:28], id_index26, 2'b00}, where id_pc4=id_pc+4.
  - 11: {rs_val[31:2], 2'b00}.
  - All additions are modulo 2^32 (wrap, no trap).
- Misaligned register target: if npc_sel==11, rs_val[1:0]!=0 and !stall, align_err is set and held until reset. The PC still takes the aligned value.
- Normal cycle (reset==1, stall==0):
  - PC<=NPC.
  - id_instr<=fetched word, id_pc<=PC, id_pc8<=PC+8, id_valid<=1.
  - fetch_cnt<=fetch_cnt+1 when in_range; wraps at 2^32.
- Stall cycle (reset==1, stall==1):
  - PC, all IF/ID outputs, id_valid and fetch_cnt hold.
  - npc_sel, br_true and rs_val are ignored; the ID instruction re-presents them on the next non-stalled cycle.
- Latency: an instruction at address A appears on id_instr one edge after PC==A with stall low.
- Branch timing: a taken branch in ID redirects the PC at the same edge its delay slot enters IF/ID; no flush is ever generated.
- Out-of-range PC: fetch proceeds with a nop, fetch_cnt is not incremented, no error flag.
- Reset mid-stall or mid-branch: reset state as above; pending redirect discarded.

Test Plan:
- Reset then 3 free cycles with IM[0..2]=0x3c011234, 0x34210001, 0x00000000:
  - id_instr sequence 3c011234, 34210001, 0.
  - id_pc 0x3000, 0x3004, 0x3008; id_pc8 0x3008 first.
  - fetch_cnt=3.
- Branch in ID with id_pc=0x3004, imm=0xfffe (−2), npc_sel=01, br_true=1:
  - next PC=0x3000; delay slot 0x3008 still loaded into IF/ID.
  - Same stimulus with br_true=0 → next PC=0x300c.
- npc_sel=10, id_pc=0x3010, index26=0x0000c10:
  - next PC=0x00003040.
- npc_sel=11, rs_val=0x00003022:
  - next PC=0x00003020, align_err=1 and stays 1.
  - A subsequent aligned jr leaves it set.
- stall=1 for 3 cycles with npc_sel=01, br_true=1:
  - PC, id_instr, id_pc and fetch_cnt are unchanged.
  - The redirect happens only on the first cycle with stall=0.
- Edge cases:
  - PC=0x2ffc after jr → id_instr=0, fetch_cnt unchanged.
  - reset=0 with stall=1 mid-run → PC=0x3000, id_valid=0 next edge.
